// File: rtl/bip_control_fsm.sv
// BIP multi-cycle control unit: FETCH/EXEC/WAIT/HALT sequencer with
// branches, RAM read latency, sticky halt and a retired-instruction count.
//
// Ports:
//   i_clock, i_reset (sync, active high), i_valid (global enable)
//   i_instruction   instruction memory read data
//   i_acc_zero      accumulator == 0 flag
//   o_addr_instr    PC
//   o_operand       IR operand field
//   o_sel_a/o_sel_b/o_op_code  datapath mux and ALU controls
//   o_wr_acc/o_wr_ram/o_rd_ram strobes
//   o_halted/o_illegal         stop status
//   o_instr_count   retired instructions, saturating
module bip_control_fsm #(
  parameter int NB_DATA            = 16,
  parameter int NB_OPCODE          = 5,
  parameter int NB_OPERAND         = 11,
  parameter int LOG2_N_INSMEM_ADDR = 11,
  parameter int NB_SEL_A           = 2,
  parameter int RAM_LATENCY        = 1,
  parameter int NB_COUNT           = 16
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_valid,
  input  logic [NB_DATA-1:0]            i_instruction,
  input  logic                          i_acc_zero,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_addr_instr,
  output logic [NB_OPERAND-1:0]         o_operand,
  output logic [NB_SEL_A-1:0]           o_sel_a,
  output logic                          o_sel_b,
  output logic                          o_op_code,
  output logic                          o_wr_acc,
  output logic                          o_wr_ram,
  output logic                          o_rd_ram,
  output logic                          o_halted,
  output logic                          o_illegal,
  output logic [NB_COUNT-1:0]           o_instr_count
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_HALT = NB_OPCODE'(0);
  localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
  localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
  localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
  localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
  localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
  localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
  localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);
  localparam logic [NB_OPCODE-1:0] OP_BEQ  = NB_OPCODE'(8);
  localparam logic [NB_OPCODE-1:0] OP_BNE  = NB_OPCODE'(9);
  localparam logic [NB_OPCODE-1:0] OP_JMP  = NB_OPCODE'(10);

  localparam logic [2:0] W_LAST = 3'(RAM_LATENCY - 1);

  // Branch target bits taken from the operand; zero-extended if narrower.
  localparam int NT = (LOG2_N_INSMEM_ADDR < NB_OPERAND) ?
                      LOG2_N_INSMEM_ADDR : NB_OPERAND;

  localparam logic [NB_SEL_A-1:0] SEL_RAM  = NB_SEL_A'(0);
  localparam logic [NB_SEL_A-1:0] SEL_IMM  = NB_SEL_A'(1);
  localparam logic [NB_SEL_A-1:0] SEL_ALU  = NB_SEL_A'(2);
  localparam logic [NB_SEL_A-1:0] SEL_HOLD = NB_SEL_A'(3);

  state_t                          state_q, state_d;
  logic [LOG2_N_INSMEM_ADDR-1:0]   pc_q, pc_d;
  logic [NB_DATA-1:0]              ir_q, ir_d;
  logic [2:0]                      wcnt_q, wcnt_d;
  logic [NB_COUNT-1:0]             cnt_q, cnt_d;
  logic                            ill_q, ill_d;

  logic [NB_OPCODE-1:0]            opcode;
  logic [LOG2_N_INSMEM_ADDR-1:0]   tgt;
  logic [LOG2_N_INSMEM_ADDR-1:0]   next_pc;
  logic                            is_rd;
  logic                            retire;
  logic [NB_SEL_A-1:0]             sel_a;
  logic                            sel_b, op_code;
  logic                            wr_acc, wr_ram, rd_ram;

  assign opcode = ir_q[NB_DATA-1 -: NB_OPCODE];
  assign is_rd  = (opcode == OP_LD) ||
                  (opcode == OP_ADD) ||
                  (opcode == OP_SUB);

  always_comb begin
    tgt         = '0;
    tgt[NT-1:0] = ir_q[NT-1:0];
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    next_pc = pc_q + 1'b1;
    retire  = 1'b0;
    sel_a   = SEL_HOLD;
    sel_b   = 1'b0;
    op_code = 1'b0;
    wr_acc  = 1'b0;
    wr_ram  = 1'b0;
    rd_ram  = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        ir_d    = i_instruction;
        state_d = S_EXEC;
      end
      S_EXEC, S_WAIT: begin
        case (opcode)
          OP_LD: begin
            sel_a  = SEL_RAM;
            rd_ram = 1'b1;
          end
          OP_LDI: begin
            sel_a  = SEL_IMM;
            wr_acc = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            sel_a   = SEL_ALU;
            rd_ram  = 1'b1;
            op_code = (opcode == OP_ADD);
          end
          OP_ADDI, OP_SUBI: begin
            sel_a   = SEL_ALU;
            sel_b   = 1'b1;
            wr_acc  = 1'b1;
            op_code = (opcode == OP_ADDI);
          end
          OP_STO: wr_ram = 1'b1;
          OP_BEQ: if (i_acc_zero) next_pc = tgt;
          OP_BNE: if (!i_acc_zero) next_pc = tgt;
          OP_JMP: next_pc = tgt;
          default: ;
        endcase

        if (state_q == S_EXEC) begin
          if (opcode == OP_HALT) begin
            state_d = S_HALT;
          end else if (opcode > OP_JMP) begin
            state_d = S_HALT;
            ill_d   = 1'b1;
          end else if (is_rd && RAM_LATENCY != 0) begin
            state_d = S_WAIT;
            wcnt_d  = '0;
          end else begin
            retire = 1'b1;
            if (is_rd) wr_acc = 1'b1;
          end
        end else begin
          // Accumulator captures RAM data only in the last wait cycle.
          if (wcnt_q == W_LAST) begin
            wr_acc = 1'b1;
            retire = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 3'd1;
          end
        end

        if (retire) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase

    // A frozen cycle must not strobe, else resuming would duplicate writes.
    if (!i_valid) begin
      wr_acc = 1'b0;
      wr_ram = 1'b0;
      rd_ram = 1'b0;
    end

    if (i_reset) begin
      sel_a   = SEL_HOLD;
      sel_b   = 1'b0;
      op_code = 1'b0;
      wr_acc  = 1'b0;
      wr_ram  = 1'b0;
      rd_ram  = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
    end else if (i_valid) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
    end
  end

  assign o_addr_instr  = pc_q;
  assign o_operand     = ir_q[NB_OPERAND-1:0];
  assign o_sel_a       = sel_a;
  assign o_sel_b       = sel_b;
  assign o_op_code     = op_code;
  assign o_wr_acc      = wr_acc;
  assign o_wr_ram      = wr_ram;
  assign o_rd_ram      = rd_ram;
  assign o_halted      = (state_q == S_HALT);
  assign o_illegal     = ill_q;
  assign o_instr_count = cnt_q;

endmodule
